button_event_encoder: RTL and testbench

//   Consumer end of the debounced pushbutton path: turns N clean button levels into a

---
 rtl/button_event_pkg.sv | 22 ++
 rtl/evt_fifo.sv | 58 +++++
 rtl/button_event_encoder.sv | 202 ++++++++++++++++++++
 tb/tb_button_event_encoder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/button_event_pkg.sv
// Shared types for the button event encoder: event codes, per-button
// FSM states and a small helper used to size the hold counters.
package button_event_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_RELEASE = 2'd1,
        EVT_LONG    = 2'd2,
        EVT_REPEAT  = 2'd3
    } evt_type_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } btn_state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/evt_fifo.sv
// Synchronous event FIFO with registered storage and head read-out.
// Ports: clk, rst (sync, active high), i_push/i_din, i_pop, o_dout (head),
// o_full, o_empty. A push while full is accepted only alongside a pop.
module evt_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [1:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  T     i_din,
    input  logic i_pop,
    output T     o_dout,
    output logic o_full,
    output logic o_empty
);

    localparam int PW = $clog2(DEPTH);

    T               r_mem [DEPTH];
    logic [PW-1:0]  r_wr;
    logic [PW-1:0]  r_rd;
    logic [PW:0]    r_cnt;
    logic           w_push;
    logic           w_pop;

    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_din;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd];
    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == (PW+1)'(DEPTH));

endmodule

// File: rtl/button_event_encoder.sv
// Turns N debounced button levels into PRESS/RELEASE/LONG(/REPEAT) events
// queued in a FIFO behind a valid/ready handshake.
// Ports: clk, rst (sync, active high), btn_in, evt_valid/evt_ready,
// evt_btn, evt_type, btn_held (per-button HELD flag), overflow (sticky).
// Macro AUTO_REPEAT_EN: when defined, HELD buttons emit periodic REPEAT.
module button_event_encoder
    import button_event_pkg::*;
#(
    parameter  int N_BTN         = 5,
    parameter  int LONG_CYCLES   = 8,
    parameter  int REPEAT_CYCLES = 4,
    parameter  int FIFO_DEPTH    = 4,
    localparam int IDX_W         = $clog2(N_BTN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDX_W-1:0] evt_btn,
    output logic [1:0]       evt_type,
    output logic [N_BTN-1:0] btn_held,
    output logic             overflow
);

    localparam int CNT_W = $clog2(max2(LONG_CYCLES, REPEAT_CYCLES));
    localparam logic [CNT_W-1:0] CNT_LONG = CNT_W'(LONG_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] CNT_REP = CNT_W'(REPEAT_CYCLES - 1);
`endif

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        evt_type_e        etype;
    } evt_rec_t;

    logic [N_BTN-1:0]      r_btn_q;
    logic                  r_overflow;
    logic [N_BTN-1:0]      w_pend_v;
    logic [N_BTN-1:0][1:0] w_pend_t;
    logic [N_BTN-1:0]      w_ovf;
    logic [IDX_W-1:0]      w_gidx;
    evt_type_e             w_gtype;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    evt_rec_t              w_din;
    evt_rec_t              w_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_q    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_btn_q    <= btn_in;
            r_overflow <= r_overflow | (|w_ovf);
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        btn_state_e       r_state;
        btn_state_e       w_next;
        logic [CNT_W-1:0] r_cnt;
        logic             r_pv;
        evt_type_e        r_pt;
        logic             w_rise;
        logic             w_fall;
        logic             w_post;
        logic             w_clr;
        logic             w_take;
        evt_type_e        w_ptype;

        assign w_rise = btn_in[g] & ~r_btn_q[g];
        assign w_fall = ~btn_in[g] & r_btn_q[g];
        assign w_take = w_push & (w_gidx == IDX_W'(g));

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_next;
                if ((w_next != r_state) || w_clr) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        always_comb begin
            w_next = r_state;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_rise) w_next = ST_PRESSED;
                end
                ST_PRESSED: begin
                    if (w_fall) w_next = ST_IDLE;
                    else if (r_cnt == CNT_LONG) w_next = ST_HELD;
                end
                ST_HELD: begin
                    if (w_fall) w_next = ST_IDLE;
                end
                default: w_next = ST_IDLE;
            endcase
        end

        // Release is checked first so it beats a threshold hit.
        always_comb begin
            w_post  = 1'b0;
            w_ptype = EVT_PRESS;
            w_clr   = 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_post  = 1'b1;
                        w_ptype = EVT_PRESS;
                    end
                end
                ST_PRESSED: begin
                    if (w_fall) begin
                        w_post  = 1'b1;
                        w_ptype = EVT_RELEASE;
                    end else if (r_cnt == CNT_LONG) begin
                        w_post  = 1'b1;
                        w_ptype = EVT_LONG;
                    end
                end
                ST_HELD: begin
                    if (w_fall) begin
                        w_post  = 1'b1;
                        w_ptype = EVT_RELEASE;
                    end
`ifdef AUTO_REPEAT_EN
                    else if (r_cnt == CNT_REP) begin
                        w_post  = 1'b1;
                        w_ptype = EVT_REPEAT;
                        w_clr   = 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end

        // A post landing on the slot being granted keeps the new event.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_pv <= 1'b0;
                r_pt <= EVT_PRESS;
            end else if (w_post) begin
                r_pv <= 1'b1;
                r_pt <= w_ptype;
            end else if (w_take) begin
                r_pv <= 1'b0;
            end
        end

        assign w_ovf[g]    = w_post & r_pv & ~w_take;
        assign w_pend_v[g] = r_pv;
        assign w_pend_t[g] = r_pt;
        assign btn_held[g] = (r_state == ST_HELD);
    end

    // Lowest-index pending slot wins.
    always_comb begin
        w_gidx  = '0;
        w_gtype = EVT_PRESS;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (w_pend_v[i]) begin
                w_gidx  = IDX_W'(i);
                w_gtype = evt_type_e'(w_pend_t[i]);
            end
        end
    end

    assign w_pop       = evt_valid & evt_ready;
    assign w_push      = (|w_pend_v) & (~w_full | w_pop);
    assign w_din.idx   = w_gidx;
    assign w_din.etype = w_gtype;

    evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (evt_rec_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign evt_valid = ~w_empty;
    assign evt_btn   = w_head.idx;
    assign evt_type  = w_head.etype;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_button_event_encoder.sv
// Directed bench for button_event_encoder with default parameters.
module tb_button_event_encoder;

    localparam logic [1:0] P  = 2'd0;
    localparam logic [1:0] R  = 2'd1;
    localparam logic [1:0] L  = 2'd2;
    localparam logic [1:0] RP = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn_in = '0;
    logic       evt_valid;
    logic       evt_ready = 1'b1;
    logic [2:0] evt_btn;
    logic [1:0] evt_type;
    logic [4:0] btn_held;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [4:0] got_q [$];
    int         got_c [$];
    logic [4:0] exp_q [$];

    button_event_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_btn   (evt_btn),
        .evt_type  (evt_type),
        .btn_held  (btn_held),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            got_q.push_back({evt_btn, evt_type});
            got_c.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic [2:0] b, input logic [1:0] t);
        exp_q.push_back({b, t});
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_cnt"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        got_q.delete();
        got_c.delete();
        exp_q.delete();
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_held", 32'(btn_held), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_btn", 32'(evt_btn), 0);
        check("rst_type", 32'(evt_type), 0);
        step(2);

        // short press on button 2
        btn_in = 5'b00100;
        step(1);
        check("p2_lat1", 32'(evt_valid), 0);
        step(1);
        check("p2_lat2", 32'(evt_valid), 1);
        check("p2_btn", 32'(evt_btn), 2);
        check("p2_type", 32'(evt_type), 32'(P));
        step(1);
        btn_in = '0;
        step(6);
        expect_ev(3'd2, P);
        expect_ev(3'd2, R);
        check_seq("short");

        // 12-cycle hold on button 0
        btn_in = 5'b00001;
        step(8);
        check("l0_held_pre", 32'(btn_held), 0);
        step(1);
        check("l0_held_on", 32'(btn_held), 1);
        step(3);
        check("l0_held_end", 32'(btn_held), 1);
        btn_in = '0;
        step(1);
        check("l0_held_off", 32'(btn_held), 0);
        step(5);
        check("long_gap", (got_c.size() >= 2) ? 32'(got_c[1] - got_c[0]) : 0, 8);
        expect_ev(3'd0, P);
        expect_ev(3'd0, L);
        expect_ev(3'd0, R);
        check_seq("long");

        // 18-cycle hold on button 0
        btn_in = 5'b00001;
        step(18);
        btn_in = '0;
        step(6);
        expect_ev(3'd0, P);
        expect_ev(3'd0, L);
`ifdef AUTO_REPEAT_EN
        expect_ev(3'd0, RP);
        expect_ev(3'd0, RP);
`endif
        expect_ev(3'd0, R);
        check_seq("rep");

        // buttons 1 and 3 together
        btn_in = 5'b01010;
        step(2);
        check("dual_b1", 32'(evt_btn), 1);
        check("dual_t1", 32'(evt_type), 32'(P));
        step(1);
        check("dual_b3", 32'(evt_btn), 3);
        check("dual_v3", 32'(evt_valid), 1);
        btn_in = '0;
        step(5);
        expect_ev(3'd1, P);
        expect_ev(3'd3, P);
        expect_ev(3'd1, R);
        expect_ev(3'd3, R);
        check_seq("dual");

        // all five with consumer stalled
        evt_ready = 1'b0;
        btn_in = 5'b11111;
        step(5);
        check("full_valid", 32'(evt_valid), 1);
        check("full_head", 32'(evt_btn), 0);
        check("full_ovf", 32'(overflow), 0);
        evt_ready = 1'b1;
        btn_in = '0;
        step(14);
        check("full_ovf2", 32'(overflow), 0);
        for (int i = 0; i < 5; i++) expect_ev(3'(i), P);
        for (int i = 0; i < 5; i++) expect_ev(3'(i), R);
        check_seq("full");

        // slot replacement while FIFO full
        evt_ready = 1'b0;
        btn_in = 5'b00110;
        step(2);
        btn_in = '0;
        step(4);
        check("ovf_head", 32'(evt_btn), 1);
        btn_in = 5'b00001;
        step(1);
        check("ovf_pre", 32'(overflow), 0);
        btn_in = '0;
        step(1);
        check("ovf_set", 32'(overflow), 1);
        evt_ready = 1'b1;
        step(10);
        check("ovf_sticky", 32'(overflow), 1);
        expect_ev(3'd1, P);
        expect_ev(3'd2, P);
        expect_ev(3'd1, R);
        expect_ev(3'd2, R);
        expect_ev(3'd0, R);
        check_seq("ovf");

        // reset while held with events queued
        evt_ready = 1'b0;
        btn_in = 5'b00001;
        step(10);
        check("rh_held", 32'(btn_held), 1);
        check("rh_valid", 32'(evt_valid), 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rh_valid0", 32'(evt_valid), 0);
        check("rh_held0", 32'(btn_held), 0);
        check("rh_ovf0", 32'(overflow), 0);
        step(2);
        check("rh_re_v", 32'(evt_valid), 1);
        check("rh_re_t", 32'(evt_type), 32'(P));
        evt_ready = 1'b1;
        btn_in = '0;
        step(5);
        expect_ev(3'd0, P);
        expect_ev(3'd0, R);
        check_seq("rh");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
